// File: rtl/data_ram_resp.sv
// Data-side memory responder: one word-addressed read/write at a time on a byte-lane word array.
// Latency: acknowledge WAIT_CYCLES+1 cycles after the request is sampled; one access per WAIT_CYCLES+2 cycles.
// Backpressure: no ready handshake; mem_busy_out is high while a request is in flight and requests are ignored then.
module data_ram_resp #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_in,
  input  logic        mem_we_in,
  input  logic [31:0] mem_addr_in,
  input  logic [3:0]  mem_sel_in,
  input  logic [31:0] mem_data_in,
  output logic        mem_ack_out,
  output logic [31:0] mem_data_out,
  output logic        mem_err_out,
  output logic        mem_busy_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Request captured at the acceptance edge; address kept as a word address.
  logic        we_q;
  logic [29:0] addr_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;

  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem_q [2**ADDR_WIDTH];

  // Access controls: with zero wait the access happens on the acceptance edge
  // straight from the inputs, otherwise from the captured request.
  logic                  acc_en;
  logic                  acc_we;
  logic [29:0]           acc_addr;
  logic [3:0]            acc_sel;
  logic [31:0]           acc_wdata;
  logic                  acc_oor;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           lane_mask;

  // Byte offset bits carry no meaning for a word-addressed array.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr_in[1:0];

  // Select the request operands used for the array access this cycle.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_sel   = sel_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_we    = mem_we_in;
      acc_addr  = mem_addr_in[31:2];
      acc_sel   = mem_sel_in;
      acc_wdata = mem_data_in;
    end
    acc_en    = ((state_q == S_IDLE) && mem_ce_in && ZERO_WAIT) ||
                ((state_q == S_WAIT) && (cnt_q == 4'd0));
    acc_idx   = acc_addr[ADDR_WIDTH-1:0];
    acc_oor   = ((acc_addr >> ADDR_WIDTH) != 30'd0);
    lane_mask = {{8{acc_sel[3]}}, {8{acc_sel[2]}}, {8{acc_sel[1]}}, {8{acc_sel[0]}}};
  end

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and wait-counter logic; mem_ce_in only matters in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_ce_in) begin
          cnt_d   = CNT_LOAD;
          state_d = ZERO_WAIT ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = 4'(cnt_q - 4'd1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Busy is a pure decode of the registered state, used upstream as a stall.
  always_comb begin
    mem_busy_out = (state_q != S_IDLE);
  end

  assign mem_ack_out  = ack_q;
  assign mem_err_out  = err_q;
  assign mem_data_out = rdata_q;

  // Counter and response registers; response fields live for the RESP cycle only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      cnt_q   <= cnt_d;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      if (acc_en) begin
        ack_q <= 1'b1;
        if (acc_oor) begin
          err_q <= 1'b1;
        end else if (!acc_we) begin
          rdata_q <= mem_q[acc_idx] & lane_mask;
        end
      end
    end
  end

  // Request capture at the acceptance edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && mem_ce_in) begin
      we_q    <= mem_we_in;
      addr_q  <= mem_addr_in[31:2];
      sel_q   <= mem_sel_in;
      wdata_q <= mem_data_in;
    end
  end

  // Array write of the selected lanes; reset on the access edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst && acc_en && acc_we && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_sel[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/data_ram_resp.md
# data_ram_resp

Responder end of the memory-stage load/store interface: accepts one word-addressed read or write request at a time from the memory stage, waits a programmable number of cycles, performs the access on an internal word array with byte-lane selects, and returns a single-cycle acknowledge with read data. It sits beside the memory stage in the pipeline. It is the data-side memory model that load/store instructions and the pipeline stall logic are built against.

## Interface

Parameters:
- ADDR_WIDTH, 10, word-index width; array depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, extra cycles between request acceptance and acknowledge; legal range 0..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active low: rst==0 at a rising edge resets the block.
- mem_ce_in  in  1  request valid.
- mem_we_in  in  1  1 = write, 0 = read.
- mem_addr_in  in  32  byte address; bits [1:0] are ignored.
- mem_sel_in  in  4  byte-lane enables; bit i covers data bits [8i+7:8i].
- mem_data_in  in  32  write data.
- mem_ack_out  out  1  one-cycle acknowledge.
- mem_data_out  out  32  read data, valid only while mem_ack_out=1.
- mem_err_out  out  1  address out of range, valid only while mem_ack_out=1.
- mem_busy_out  out  1  1 whenever state is not IDLE; used by the pipeline as a stall request.

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE: if mem_ce_in=1 at an edge, capture we, addr, sel and data into internal registers and go to WAIT. Load the wait counter with WAIT_CYCLES-1. When WAIT_CYCLES=0, go directly to RESP. Inputs are sampled only at this acceptance edge.
- WAIT: decrement the counter each edge. At the edge where the counter is 0, perform the access and go to RESP.
- Access, on the edge entering RESP:
  - Word index = captured addr[ADDR_WIDTH+1:2].
  - Out of range means addr[31:ADDR_WIDTH+2] is nonzero. In that case set err=1 and data_out=0, and leave the array untouched.
  - Write: update only the lanes with sel=1. Set data_out=0.
  - Read: data_out = the stored word with non-selected lanes forced to 0.
  - In every case register ack=1.
- RESP: mem_ack_out=1 for exactly this cycle. At the next edge go to IDLE and clear ack, err and data_out.
- mem_ce_in is ignored in WAIT and RESP.
- If mem_ce_in is still 1 in the first IDLE cycle after RESP, that is a new request (back-to-back). The initiator drops mem_ce_in in the cycle after it sees ack.
- Write followed immediately by read of the same word returns the new data.
- Reset, when rst=0 at an edge:
  - state=IDLE, counter=0.
  - mem_ack_out=0, mem_data_out=0, mem_err_out=0, mem_busy_out=0.
  - Any in-flight request is abandoned. A write is not committed if reset coincides with the RESP-entry edge; reset has priority.
  - Array contents are not reset; reading before writing returns undefined data.

## Timing

- All outputs are registered or decoded from registered state; there are no combinational paths from input to output.
- Latency: mem_ce_in high in cycle 0 (sampled at the end of cycle 0) gives mem_ack_out high in cycle WAIT_CYCLES+1.
- Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- mem_busy_out is high from cycle 1 through the ack cycle inclusive.
- Throughput: one access per WAIT_CYCLES+2 cycles.

## Test plan

- Reset: hold rst=0 for 2 cycles with mem_ce_in=1. Required: all outputs 0 and no ack. After release, the first request is accepted normally.
- Full write/read (WAIT_CYCLES=2): write 0xDEADBEEF to address 0x10 with sel=1111, then read 0x10 with sel=1111.
  - Each ack arrives 3 cycles after ce; the read returns 0xDEADBEEF with err=0.
  - busy is high for 3 cycles per access.
- Byte lanes:
  - Write 0x0000AA00 with sel=0010 to 0x10; a read with sel=1111 then returns 0xDEADAAEF.
  - A read with sel=1100 returns 0xDEAD0000.
- Out of range (ADDR_WIDTH=10): write to 0x1000. Required: ack with err=1 and data 0. A read of 0x0 is unchanged from its prior value.
- Reset mid-operation: start a write of 0x12345678 to 0x20 and pull rst=0 during WAIT.
  - Required: no ack, busy drops after the reset edge.
  - A later read of 0x20 returns its old value.
- Back-to-back and zero wait (WAIT_CYCLES=0): hold mem_ce_in=1 with alternating addresses. Required: ack in cycle 1 and a new acceptance every 2 cycles. Toggling ce during RESP has no effect.
